// File: rtl/clock_enable_gen.sv
// Programmable per-channel clock-enable generator: each channel emits a one-cycle
// enable pulse every N cycles plus a square-wave tick of period 2N.
module clock_enable_gen #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                sync,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_div,
    output logic [CHANNELS-1:0] enable,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    // The >= guards the counter against ever running past N-1, even if the
    // divisor were somehow smaller than the current count.
    function automatic logic at_wrap(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] n);
        return (n != '0) && (c >= n - WIDTH'(1));
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] act;
        logic [WIDTH-1:0] shd;
        logic [WIDTH-1:0] shd_nxt;
        logic             wr_hit;
        logic             wrap;
        logic             en_q;
        logic             tick_q;

        // Out-of-range channel indices never match any channel, so they are dropped.
        assign wr_hit  = wr_en && (32'(wr_ch) == i);
        // A write landing on the load cycle takes effect at that same load.
        assign shd_nxt = wr_hit ? wr_div : shd;
        assign wrap    = run && at_wrap(cnt, act);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt    <= '0;
                act    <= DIV_RST;
                shd    <= DIV_RST;
                en_q   <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                shd  <= shd_nxt;
                en_q <= 1'b0;
                if (sync) begin
                    cnt    <= '0;
                    tick_q <= 1'b0;
                    act    <= shd_nxt;
                end else if (run) begin
                    if (act == '0) begin
                        cnt <= '0;
                        act <= shd_nxt;
                    end else if (wrap) begin
                        cnt    <= '0;
                        en_q   <= 1'b1;
                        tick_q <= ~tick_q;
                        act    <= shd_nxt;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
            end
        end

        assign enable[i] = en_q;
        assign tick[i]   = tick_q;
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomized scoreboard bench for clock_enable_gen: a phase-counting reference
// model predicts enable/tick per cycle, a monitor compares them against the DUT.
module tb_clock_enable_gen;

    localparam int CH   = 5;
    localparam int W    = 4;
    localparam int DEFD = 2;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          sync = 1'b0;
    logic          wr_en = 1'b0;
    logic [CW-1:0] wr_ch = '0;
    logic [W-1:0]  wr_div = '0;
    logic [CH-1:0] enable;
    logic [CH-1:0] tick;

    clock_enable_gen #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEFD)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .enable(enable), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] en;
        logic [CH-1:0] tk;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model: phase position within the period, divisors, tick level.
    int   m_pos [CH];
    int   m_act [CH];
    int   m_shd [CH];
    bit   m_tk  [CH];

    function automatic exp_t model_step(bit r_n, bit rn, bit sy, bit we, int wc, int wd);
        exp_t e;
        e = '0;
        for (int i = 0; i < CH; i++) begin
            int nshd;
            if (!r_n) begin
                m_pos[i] = 0; m_act[i] = DEFD; m_shd[i] = DEFD; m_tk[i] = 0;
            end else begin
                nshd = (we && wc == i) ? wd : m_shd[i];
                if (sy) begin
                    m_pos[i] = 0; m_tk[i] = 0; m_act[i] = nshd;
                end else if (rn) begin
                    if (m_act[i] == 0) begin
                        m_pos[i] = 0; m_act[i] = nshd;
                    end else begin
                        m_pos[i] = (m_pos[i] + 1) % m_act[i];
                        if (m_pos[i] == 0) begin
                            e.en[i]  = 1'b1;
                            m_tk[i]  = !m_tk[i];
                            m_act[i] = nshd;
                        end
                    end
                end
                m_shd[i] = nshd;
            end
            e.tk[i] = m_tk[i];
        end
        return e;
    endfunction

    task automatic drive(bit r_n, bit rn, bit sy, bit we, int wc, int wd);
        @(negedge clk);
        rst_n  = r_n;
        run    = rn;
        sync   = sy;
        wr_en  = we;
        wr_ch  = CW'(wc);
        wr_div = W'(wd);
        q.push_back(model_step(r_n, rn, sy, we, wc % (1 << CW), wd));
    endtask

    // Monitor: outputs are checked 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (enable !== e.en) begin
                n_err++;
                $display("FAIL enable @%0t: got %b expected %b", $time, enable, e.en);
            end
            n_chk++;
            if (tick !== e.tk) begin
                n_err++;
                $display("FAIL tick @%0t: got %b expected %b", $time, tick, e.tk);
            end
        end
    end

    initial begin
        int hold;
        // Reset, then default divisor free-running.
        repeat (3) drive(0, 1, 0, 0, 0, 0);
        repeat (12) drive(1, 1, 0, 0, 0, 0);
        // Ch1 to N=3, then N=5 mid-period; ch2 to 0 then 3.
        drive(1, 1, 0, 1, 1, 3);
        repeat (4) drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 1, 5);
        drive(1, 1, 0, 1, 2, 0);
        repeat (8) drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 2, 3);
        repeat (8) drive(1, 1, 0, 0, 0, 0);
        // Ch3 N=4, hold run low 7 cycles mid-period.
        drive(1, 1, 0, 1, 3, 4);
        repeat (6) drive(1, 1, 0, 0, 0, 0);
        repeat (7) drive(1, 0, 0, 0, 0, 0);
        repeat (6) drive(1, 1, 0, 0, 0, 0);
        // Sync with ch0 N=2 and ch1 N=6.
        drive(1, 1, 0, 1, 0, 2);
        drive(1, 1, 0, 1, 1, 6);
        repeat (3) drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        repeat (14) drive(1, 1, 0, 0, 0, 0);
        // N=1 and out-of-range channel writes.
        drive(1, 1, 0, 1, 4, 1);
        repeat (4) drive(1, 1, 0, 1, 5 + ($urandom % 3), 7);
        drive(1, 1, 1, 0, 0, 0);
        repeat (4) drive(1, 1, 0, 0, 0, 0);
        // Reset mid-period together with an out-of-range write.
        drive(0, 1, 1, 1, CH, 9);
        repeat (6) drive(1, 1, 0, 0, 0, 0);
        // Randomized traffic.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            bit rn, sy, we, r_n;
            int wd;
            if (hold == 0 && $urandom % 50 == 0) hold = $urandom_range(1, 8);
            rn   = (hold == 0);
            if (hold > 0) hold--;
            sy   = ($urandom % 60 == 0);
            we   = ($urandom % 8 == 0);
            wd   = ($urandom % 6 == 0) ? $urandom_range(0, 1) : $urandom_range(0, 15);
            r_n  = ($urandom % 400 != 0);
            drive(r_n, rn, sy, we, $urandom_range(0, 7), wd);
        end
        repeat (2) drive(1, 1, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent enable channels, range 1..16.
REQ-002 Parameter WIDTH, default 8: divisor and counter width in bits, range 2..32.
REQ-003 Parameter DEFAULT_DIV, default 2: divisor loaded into every channel at reset, must be < 2^WIDTH.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 run  input  1  global count enable; low freezes all channels.
REQ-007 sync  input  1  one-cycle strobe; phase-aligns all channels.
REQ-008 wr_en  input  1  divisor write strobe.
REQ-009 wr_ch  input  $clog2(CHANNELS) (min 1)  channel index for the write.
REQ-010 wr_div  input  WIDTH  new divisor N for channel wr_ch.
REQ-011 enable  output  CHANNELS  registered one-cycle enable pulse per channel.
REQ-012 tick  output  CHANNELS  registered square wave per channel, period 2N.

Function
REQ-013 Each channel SHALL hold three registers: counter[WIDTH], active divisor, and shadow divisor.
REQ-014 When run=1, N>=2, sync=0: counter SHALL increment each cycle; when counter==N-1 it SHALL wrap to 0 (wrap event).
REQ-015 enable[i] SHALL be 1 in the cycle after a wrap event edge and 0 otherwise: exactly one pulse per N run cycles.
REQ-016 After reset release with run=1, the first enable[i] pulse SHALL appear after the Nth rising edge (N=3: high after edge 3, low after edge 4).
REQ-017 tick[i] SHALL toggle on every wrap event: 50% duty, period 2N cycles.
REQ-018 N=1: enable[i] SHALL be 1 on every cycle while run=1, and tick[i] SHALL toggle every cycle.
REQ-019 N=0: channel disabled; counter held at 0, enable[i]=0, tick[i] holds its value.
REQ-020 run=0: counters, tick and divisors SHALL hold, and enable SHALL be 0 on the next cycle; counting resumes from the held value.
REQ-021 wr_en=1: wr_div SHALL be written to shadow[wr_ch]; wr_ch >= CHANNELS SHALL be ignored.
REQ-022 Active divisor SHALL load from shadow at a wrap event, on sync, or immediately if the current active divisor is 0.
REQ-023 A write coinciding with a wrap event on the same channel SHALL bypass to active at that wrap.
REQ-024 A write SHALL never truncate or extend the period in progress, except when N=0 (REQ-022).
REQ-025 sync=1 SHALL, in that cycle, clear all counters and tick bits to 0, load active from shadow, and suppress enable; this takes priority over run and wrap.
REQ-026 sync=1 with run=1 SHALL realign channels with N=2 and N=4: every second channel-A pulse coincides with a channel-B pulse.
REQ-027 The counter compare SHALL use unsigned WIDTH-bit arithmetic, and the counter SHALL never exceed N-1.

Reset
REQ-028 While rst_n=0 at a rising edge: counters=0, enable=0, tick=0, active=shadow=DEFAULT_DIV for all channels.
REQ-029 Reset SHALL dominate sync, wr_en and run, and reset mid-period SHALL discard the partial count.
REQ-030 No output SHALL change without a clock edge; no asynchronous paths.

Verification
REQ-031 Reset, run=1, DEFAULT_DIV=2 -> every enable bit high every 2nd cycle, first pulse after edge 2; tick period 4.
REQ-032 Write N=5 to ch1 when counter=1 (old N=3) -> current period completes at 3, then pulses every 5 cycles; ch0/2/3 unaffected.
REQ-033 Write N=0 to ch2 -> enable[2] stays 0 after the next wrap; write N=3 -> counting restarts immediately, first pulse 3 cycles later.
REQ-034 run low for 7 cycles mid-period (counter=2, N=4) -> no pulses, tick frozen; pulse 2 cycles after run returns high.
REQ-035 sync with ch0 N=2, ch1 N=6 mid-count -> both counters 0 next cycle, no enable that cycle; pulses coincide every 6 cycles.
REQ-036 Assert rst_n=0 for 1 cycle mid-period and drive wr_ch=CHANNELS -> all outputs 0, divisors=DEFAULT_DIV; the out-of-range write has no effect.
